zjh_vote_ctrl: RTL and testbench
================================

# zjh_vote_ctrl

Parametrised, clocked multi-voter voting controller. It replaces the fixed 3-input combinational majority voter with a registered vote-collection round. A round has a timed voting window, first-press-wins latching per voter, yes/no tallies, a configurable pass threshold and a held verdict. It sits between debounced voter push-button inputs and the result indicators/display in the lab voting design.

## Interface
- N, 3: number of voters (2..16).
- THRESH, N/2+1: minimum yes count for pass (1..N).
- WINDOW, 8: maximum length of the voting window, in clock cycles (≥1).
- CW (localparam): $clog2(N+1), tally width.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  one-cycle request to open a new round.
- abort  in  1  cancels an open round.
- yes_in  in  N  per-voter yes press, bit i = voter i.
- no_in  in  N  per-voter no press.
- busy  out  1  high while window open (COLLECT).
- voted  out  N  bit i set once voter i's vote is latched.
- yes_cnt  out  CW  registered yes tally.
- no_cnt  out  CW  registered no tally.
- done  out  1  one-cycle pulse when verdict becomes valid.
- pass  out  1  held verdict: yes_cnt ≥ THRESH.
- fail  out  1  held verdict: complement of pass, only when verdict valid.

## Operation
- States: IDLE, COLLECT, DECIDE, SHOW.
- IDLE: all outputs 0. start=1 → COLLECT. Entering COLLECT clears voted, yes_cnt, no_cnt, timer, pass, fail.
- COLLECT: for every i with voted[i]=0:
  - yes_in[i]=1 → voted[i]←1 and counted as yes. This applies even if no_in[i]=1 too; yes has priority.
  - else no_in[i]=1 → voted[i]←1 and counted as no.
  - Presses from voters already latched are ignored.
- Simultaneous presses from several voters in one cycle are all counted: tally += popcount. Counts never exceed N; no wrap.
- Timer increments each COLLECT cycle.
- Leave COLLECT → DECIDE at the edge where either of these holds:
  - next-voted is all ones (early close);
  - timer == WINDOW-1 (timeout).
  Votes sampled on that same edge are counted.
- abort=1 in COLLECT → IDLE. Counts and voted are cleared, and no done is issued. abort has priority over votes and over close. abort in other states is ignored.
- start in COLLECT or DECIDE is ignored.
- DECIDE (1 cycle): pass←(yes_cnt ≥ THRESH), fail←!that, done←1 → SHOW.
- SHOW: pass, fail and tallies held, done=0. start=1 → COLLECT (new round, cleared as above).
- Voters who never voted count as neither yes nor no.

## Timing
- Reset (async assert, any state): state=IDLE; busy, voted, yes_cnt, no_cnt, done, pass and fail all 0. Reset mid-round discards the round.
- start sampled at edge t → busy=1 after t. busy falls at the edge the window closes.
- A vote sampled at edge k shows in voted and the tally after k.
- Window length: at most WINDOW sampling edges, counted from the edge after start.
- Early close on edge k → done=1, with pass/fail valid, after edge k+1. done is 1 cycle wide.
- pass and fail are never both 1. Both are 0 outside DECIDE result/SHOW.
- All outputs registered; no combinational input→output paths.

## Test plan
- N=3, THRESH=2, WINDOW=8. start; voter0 yes, voter1 yes, voter2 no on separate cycles → early close after third vote, yes_cnt=2, no_cnt=1, done pulse, pass=1, fail=0.
- Same params. start; only voter2 yes, then idle → busy high exactly 8 cycles, then done, yes_cnt=1, no_cnt=0, pass=0, fail=1.
- Same params. start; yes_in=3'b111 and no_in=3'b001 in one cycle → voted=3'b111, yes_cnt=3, no_cnt=0, pass=1. Later presses do not change the tallies.
- Same params. start; voter0 no, then voter0 yes → yes_cnt=0, no_cnt=1; the second press is ignored.
- Same params. start; voter0 yes; abort → IDLE, busy=0, yes_cnt=0, no done. Then assert rst mid-round → all outputs 0 immediately, without waiting for a clock edge.
- N=5, THRESH=4, WINDOW=4. Four yes votes in cycle 1 → pass=1. In a second round from SHOW, three yes votes → fail=1 after timeout, with tallies cleared at round start.

Source files
------------

// File: rtl/zjh_vote_ctrl.sv
// Clocked multi-voter vote collection: timed window, first-press-wins latching,
// yes/no tallies and a held pass/fail verdict against a threshold.
module zjh_vote_ctrl #(
  parameter int unsigned N      = 3,
  parameter int unsigned THRESH = N / 2 + 1,
  parameter int unsigned WINDOW = 8,
  localparam int unsigned CW    = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [N-1:0]  yes_in,
  input  logic [N-1:0]  no_in,
  output logic          busy,
  output logic [N-1:0]  voted,
  output logic [CW-1:0] yes_cnt,
  output logic [CW-1:0] no_cnt,
  output logic          done,
  output logic          pass,
  output logic          fail
);

  localparam int unsigned TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DECIDE,
    S_SHOW
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    voted_q, voted_d;
  logic [CW-1:0]   yes_q, yes_d;
  logic [CW-1:0]   no_q, no_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;

  logic [N-1:0]    new_yes, new_no, voted_nx;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // Yes wins over a simultaneous no; already-latched voters are masked out.
  assign new_yes  = yes_in & ~voted_q;
  assign new_no   = no_in & ~yes_in & ~voted_q;
  assign voted_nx = voted_q | new_yes | new_no;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      voted_q <= '0;
      yes_q   <= '0;
      no_q    <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      voted_q <= voted_d;
      yes_q   <= yes_d;
      no_q    <= no_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    voted_d = voted_q;
    yes_d   = yes_q;
    no_d    = no_q;
    timer_d = timer_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;

    unique case (state_q)
      S_IDLE, S_SHOW: begin
        if (start) begin
          state_d = S_COLLECT;
          busy_d  = 1'b1;
          voted_d = '0;
          yes_d   = '0;
          no_d    = '0;
          timer_d = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      S_COLLECT: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          voted_d = '0;
          yes_d   = '0;
          no_d    = '0;
          timer_d = '0;
        end else begin
          voted_d = voted_nx;
          yes_d   = yes_q + popcnt(new_yes);
          no_d    = no_q + popcnt(new_no);
          timer_d = timer_q + TW'(1);
          if ((&voted_nx) || (timer_q == TW'(WINDOW - 1))) begin
            state_d = S_DECIDE;
            busy_d  = 1'b0;
          end
        end
      end
      S_DECIDE: begin
        state_d = S_SHOW;
        done_d  = 1'b1;
        pass_d  = (yes_q >= CW'(THRESH));
        fail_d  = !(yes_q >= CW'(THRESH));
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign voted   = voted_q;
  assign yes_cnt = yes_q;
  assign no_cnt  = no_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;

endmodule

// File: tb/tb_zjh_vote_ctrl.sv
// Scoreboard bench for zjh_vote_ctrl: two instances (N=3/T=2/W=8 and N=5/T=4/W=4)
// driven by directed and random rounds, checked against a per-round voting model.
module tb_zjh_vote_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       st_a, ab_a, busy_a, done_a, pass_a, fail_a;
  logic [2:0] y_a, n_a, voted_a;
  logic [1:0] yc_a, nc_a;
  logic       st_b, ab_b, busy_b, done_b, pass_b, fail_b;
  logic [4:0] y_b, n_b, voted_b;
  logic [2:0] yc_b, nc_b;

  zjh_vote_ctrl #(.N(3), .THRESH(2), .WINDOW(8)) u_a (
    .clk(clk), .rst(rst), .start(st_a), .abort(ab_a), .yes_in(y_a), .no_in(n_a),
    .busy(busy_a), .voted(voted_a), .yes_cnt(yc_a), .no_cnt(nc_a),
    .done(done_a), .pass(pass_a), .fail(fail_a));

  zjh_vote_ctrl #(.N(5), .THRESH(4), .WINDOW(4)) u_b (
    .clk(clk), .rst(rst), .start(st_b), .abort(ab_b), .yes_in(y_b), .no_in(n_b),
    .busy(busy_b), .voted(voted_b), .yes_cnt(yc_b), .no_cnt(nc_b),
    .done(done_b), .pass(pass_b), .fail(fail_b));

  logic [15:0] voted_w[2];
  logic [7:0]  yc_w[2], nc_w[2];
  logic        busy_w[2], done_w[2], pass_w[2], fail_w[2];
  assign voted_w[0] = 16'(voted_a);
  assign voted_w[1] = 16'(voted_b);
  assign yc_w[0] = 8'(yc_a);
  assign yc_w[1] = 8'(yc_b);
  assign nc_w[0] = 8'(nc_a);
  assign nc_w[1] = 8'(nc_b);
  assign busy_w[0] = busy_a;
  assign busy_w[1] = busy_b;
  assign done_w[0] = done_a;
  assign done_w[1] = done_b;
  assign pass_w[0] = pass_a;
  assign pass_w[1] = pass_b;
  assign fail_w[0] = fail_a;
  assign fail_w[1] = fail_b;

  typedef struct {
    int          yc;
    int          nc;
    bit          pass;
    bit          fail;
    int          busy;
    logic [15:0] voted;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];
  int errors = 0;
  int checks = 0;

  function automatic int nv(int d);   return (d == 0) ? 3 : 5; endfunction
  function automatic int thv(int d);  return (d == 0) ? 2 : 4; endfunction
  function automatic int winv(int d); return (d == 0) ? 8 : 4; endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: walk the window cycle by cycle; each voter keeps its first press.
  function automatic exp_t model(input int d, input logic [15:0] ys[8],
                                 input logic [15:0] ns[8], input int abort_at,
                                 output bit aborted);
    exp_t e;
    bit   has[16];
    int   yes = 0, no = 0, close = winv(d) - 1, n = nv(d);
    e.voted = '0;
    for (int i = 0; i < 16; i++) has[i] = 0;
    for (int j = 0; j < winv(d); j++) begin
      bit all = 1;
      for (int i = 0; i < n; i++) begin
        if (!has[i]) begin
          if (ys[j][i]) begin has[i] = 1; yes++; end
          else if (ns[j][i]) begin has[i] = 1; no++; end
        end
        if (!has[i]) all = 0;
      end
      if (all) begin close = j; break; end
    end
    for (int i = 0; i < n; i++) if (has[i]) e.voted[i] = 1'b1;
    e.yc = yes;
    e.nc = no;
    e.pass = (yes >= thv(d));
    e.fail = !e.pass;
    e.busy = close + 1;
    aborted = (abort_at >= 0) && (abort_at <= close);
    return e;
  endfunction

  task automatic set_in(input int d, input logic st, input logic ab,
                        input logic [15:0] y, input logic [15:0] n);
    if (d == 0) begin st_a = st; ab_a = ab; y_a = 3'(y); n_a = 3'(n); end
    else        begin st_b = st; ab_b = ab; y_b = 5'(y); n_b = 5'(n); end
  endtask

  task automatic run_round(input int d, input logic [15:0] ys[8],
                           input logic [15:0] ns[8], input int abort_at);
    exp_t e;
    bit   aborted;
    e = model(d, ys, ns, abort_at, aborted);
    if (!aborted) begin
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    set_in(d, 1'b1, 1'b0, '0, '0);
    @(posedge clk); #1;
    check("start_busy", int'(busy_w[d]), 1);
    check("start_clr_yes", int'(yc_w[d]), 0);
    check("start_clr_voted", int'(voted_w[d]), 0);
    check("start_clr_pass", int'(pass_w[d] | fail_w[d]), 0);
    for (int j = 0; j < winv(d); j++) begin
      set_in(d, 1'b0, 1'(j == abort_at), ys[j], ns[j]);
      @(posedge clk); #1;
      if (aborted && j == abort_at) begin
        check("abort_busy", int'(busy_w[d]), 0);
        check("abort_yes", int'(yc_w[d]), 0);
        check("abort_no", int'(nc_w[d]), 0);
        check("abort_voted", int'(voted_w[d]), 0);
      end
    end
    set_in(d, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever a verdict pulse appears.
  bit busy_prev[2];
  int bcnt[2];
  bit pulse_chk[2];
  always @(negedge clk) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        busy_prev[d] = 0; bcnt[d] = 0; pulse_chk[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_t e;
        if (busy_w[d] && !busy_prev[d]) bcnt[d] = 1;
        else if (busy_w[d]) bcnt[d]++;
        busy_prev[d] = busy_w[d];
        check("pass_fail_excl", int'(pass_w[d] & fail_w[d]), 0);
        if (pulse_chk[d]) begin
          check("done_width", int'(done_w[d]), 0);
          pulse_chk[d] = 0;
        end
        if (done_w[d]) begin
          if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            check("yes_cnt", int'(yc_w[d]), e.yc);
            check("no_cnt", int'(nc_w[d]), e.nc);
            check("pass", int'(pass_w[d]), int'(e.pass));
            check("fail", int'(fail_w[d]), int'(e.fail));
            check("voted", int'(voted_w[d]), int'(e.voted));
            check("busy_len", bcnt[d], e.busy);
            pulse_chk[d] = 1;
          end
        end
      end
    end
  end

  initial begin
    logic [15:0] ys[8], ns[8];
    rst = 1'b1;
    set_in(0, 1'b0, 1'b0, '0, '0);
    set_in(1, 1'b0, 1'b0, '0, '0);
    #2;
    check("rst_busy", int'(busy_a), 0);
    check("rst_outs", int'({voted_a, yc_a, nc_a, done_a, pass_a, fail_a}), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Separate-cycle votes, early close.
    for (int j = 0; j < 8; j++) begin ys[j] = '0; ns[j] = '0; end
    ys[0] = 16'h1; ys[1] = 16'h2; ns[2] = 16'h4;
    run_round(0, ys, ns, -1);
    // Single yes then timeout.
    for (int j = 0; j < 8; j++) begin ys[j] = '0; ns[j] = '0; end
    ys[0] = 16'h4;
    run_round(0, ys, ns, -1);
    // All in one cycle, yes beats no, later presses ignored.
    for (int j = 0; j < 8; j++) begin ys[j] = '0; ns[j] = '0; end
    ys[0] = 16'h7; ns[0] = 16'h1; ys[1] = 16'h7; ns[2] = 16'h7;
    run_round(0, ys, ns, -1);
    // No then yes from the same voter.
    for (int j = 0; j < 8; j++) begin ys[j] = '0; ns[j] = '0; end
    ns[0] = 16'h1; ys[1] = 16'h1;
    run_round(0, ys, ns, -1);
    // Abort after one vote.
    for (int j = 0; j < 8; j++) begin ys[j] = '0; ns[j] = '0; end
    ys[0] = 16'h1;
    run_round(0, ys, ns, 1);
    // Wide instance: pass then fail from SHOW.
    for (int j = 0; j < 8; j++) begin ys[j] = '0; ns[j] = '0; end
    ys[0] = 16'h0F;
    run_round(1, ys, ns, -1);
    ys[0] = 16'h07;
    run_round(1, ys, ns, -1);

    for (int r = 0; r < 40; r++) begin
      int d = r % 2;
      int ab = (($urandom % 8) == 0) ? int'($urandom % 8) : -1;
      logic [15:0] m = (d == 0) ? 16'h7 : 16'h1F;
      for (int j = 0; j < 8; j++) begin
        ys[j] = 16'($urandom & $urandom) & m;
        ns[j] = 16'($urandom & $urandom) & m;
      end
      run_round(d, ys, ns, ab);
    end

    // Asynchronous reset mid-round.
    set_in(0, 1'b1, 1'b0, '0, '0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, 16'h1, '0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, '0, '0);
    check("pre_rst_voted", int'(voted_a), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", int'(busy_a), 0);
    check("async_rst_outs", int'({voted_a, yc_a, nc_a, done_a, pass_a, fail_a}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
